// File: rtl/serial_bit_feeder_pkg.sv
// Shared definitions for the serial bit feeder and the alternating-pattern detector.
// Holds the FSM state encoding and the default word width and idle level.
package serial_bit_feeder_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH    = 8;
    localparam bit DEF_IDLE_LVL = 1'b0;

endpackage

// File: rtl/serial_bit_feeder_piso.sv
// Parallel-in serial-out shift register; owns the data word and the output-bit select.
// Ports: clk, rst (sync high), load (capture din), shift (advance one bit), din, dout.
module piso_shift_reg
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] sr;

    // Load wins over shift so a back-to-back word replaces the finished one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            if (MSB_FIRST) begin
                sr <= {sr[WIDTH-2:0], 1'b0};
            end else begin
                sr <= {1'b0, sr[WIDTH-1:1]};
            end
        end
    end

    assign dout = MSB_FIRST ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end feeding one bit per clock to the detector input 'a'.
// Ports: clk, rst, data_in/data_valid/data_ready handshake, a_out, bit_valid,
// frame_done (last-bit pulse), frames_sent (wrapping completed-word count).
module serial_bit_feeder
    import serial_bit_feeder_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_LVL  = DEF_IDLE_LVL,
    parameter int CNT_W     = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             a_out,
    output logic             bit_valid,
    output logic             frame_done,
    output logic [CNT_W-1:0] frames_sent
);

    localparam int            BW   = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    state_t           state;
    logic [BW-1:0]    bit_cnt;
    logic [CNT_W-1:0] cnt;
    logic             sr_out;
    logic             last;
    logic             accept;

    assign last       = (state == ST_SHIFT) && (bit_cnt == LAST);
    // Ready on the last bit too, so the next word follows without a gap.
    assign data_ready = ~rst & ((state == ST_IDLE) | last);
    assign accept     = data_valid & data_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            cnt     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (last) begin
                        cnt <= cnt + 1'b1;
                        if (accept) begin
                            bit_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (bit_valid & ~accept),
        .din   (data_in),
        .dout  (sr_out)
    );

    assign bit_valid   = (state == ST_SHIFT);
    assign frame_done  = last;
    assign a_out       = bit_valid ? sr_out : IDLE_LVL;
    assign frames_sent = cnt;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: MSB-first, LSB-first and narrow-counter builds.
// Inputs change 2 time units after each rising edge; outputs are checked 1 unit later.
module tb_serial_bit_feeder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [7:0]  d0, d1, d2;
    logic        v0, v1, v2;
    logic        r0, r1, r2;
    logic        a0, a1, a2;
    logic        bv0, bv1, bv2;
    logic        fd0, fd1, fd2;
    logic [15:0] fs0, fs1;
    logic [1:0]  fs2;

    int nchk = 0;
    int nerr = 0;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .data_in(d0), .data_valid(v0), .data_ready(r0),
        .a_out(a0), .bit_valid(bv0), .frame_done(fd0), .frames_sent(fs0));

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .data_in(d1), .data_valid(v1), .data_ready(r1),
        .a_out(a1), .bit_valid(bv1), .frame_done(fd1), .frames_sent(fs1));

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .data_in(d2), .data_valid(v2), .data_ready(r2),
        .a_out(a2), .bit_valid(bv2), .frame_done(fd2), .frames_sent(fs2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [7:0]  w;
    logic [15:0] s;

    initial begin
        d0 = '0; d1 = '0; d2 = '0;
        v0 = 0;  v1 = 0;  v2 = 0;

        // Reset state
        tick();
        #1;
        chk("rst_ready", {31'd0, r0}, 32'd0);
        chk("rst_bv", {31'd0, bv0}, 32'd0);
        chk("rst_fd", {31'd0, fd0}, 32'd0);
        chk("rst_aout", {31'd0, a0}, 32'd0);
        chk("rst_fs", {16'd0, fs0}, 32'd0);
        rst = 0;
        #1;
        chk("idle_ready", {31'd0, r0}, 32'd1);

        // 1: single word A5, one-cycle valid
        d0 = 8'hA5; v0 = 1;
        tick();
        v0 = 0; d0 = 8'h00;
        w = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t1_aout", {31'd0, a0}, {31'd0, w[7-i]});
            chk("t1_bv", {31'd0, bv0}, 32'd1);
            chk("t1_fd", {31'd0, fd0}, (i == 7) ? 32'd1 : 32'd0);
            tick();
        end
        #1;
        chk("t1_fs", {16'd0, fs0}, 32'd1);
        chk("t1_idle_aout", {31'd0, a0}, 32'd0);
        chk("t1_idle_bv", {31'd0, bv0}, 32'd0);
        chk("t1_idle_fd", {31'd0, fd0}, 32'd0);

        // 2: 55 then AA with valid held high
        rst = 1;
        tick();
        rst = 0;
        d0 = 8'h55; v0 = 1;
        tick();
        d0 = 8'hAA;
        s = 16'h55AA;
        for (int j = 0; j < 16; j++) begin
            if (j == 8) v0 = 0;
            #1;
            chk("t2_aout", {31'd0, a0}, {31'd0, s[15-j]});
            chk("t2_bv", {31'd0, bv0}, 32'd1);
            chk("t2_ready", {31'd0, r0}, (j == 7 || j == 15) ? 32'd1 : 32'd0);
            chk("t2_fd", {31'd0, fd0}, (j == 7 || j == 15) ? 32'd1 : 32'd0);
            tick();
        end
        #1;
        chk("t2_fs", {16'd0, fs0}, 32'd2);
        chk("t2_idle_bv", {31'd0, bv0}, 32'd0);

        // 4: FF presented at bit_cnt=2 must wait, then be sent exactly once
        rst = 1;
        tick();
        rst = 0;
        d0 = 8'h3C; v0 = 1;
        tick();
        v0 = 0;
        s = 16'h3CFF;
        for (int j = 0; j < 16; j++) begin
            if (j == 2) begin
                d0 = 8'hFF; v0 = 1;
            end
            if (j == 8) v0 = 0;
            #1;
            chk("t4_aout", {31'd0, a0}, {31'd0, s[15-j]});
            chk("t4_bv", {31'd0, bv0}, 32'd1);
            chk("t4_ready", {31'd0, r0}, (j == 7 || j == 15) ? 32'd1 : 32'd0);
            chk("t4_fd", {31'd0, fd0}, (j == 7 || j == 15) ? 32'd1 : 32'd0);
            tick();
        end
        #1;
        chk("t4_fs", {16'd0, fs0}, 32'd2);
        chk("t4_idle_bv", {31'd0, bv0}, 32'd0);
        tick();
        #1;
        chk("t4_no_dup_bv", {31'd0, bv0}, 32'd0);
        chk("t4_no_dup_fs", {16'd0, fs0}, 32'd2);

        // 5: reset after third bit of F0 aborts the word
        d0 = 8'hF0; v0 = 1;
        tick();
        v0 = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_aout", {31'd0, a0}, 32'd1);
            tick();
        end
        rst = 1;
        #1;
        chk("t5_rst_ready", {31'd0, r0}, 32'd0);
        chk("t5_pre_fs", {16'd0, fs0}, 32'd2);
        tick();
        rst = 0;
        #1;
        chk("t5_bv", {31'd0, bv0}, 32'd0);
        chk("t5_aout_idle", {31'd0, a0}, 32'd0);
        chk("t5_fs", {16'd0, fs0}, 32'd0);
        chk("t5_fd", {31'd0, fd0}, 32'd0);
        chk("t5_ready", {31'd0, r0}, 32'd1);
        d0 = 8'h81; v0 = 1;
        tick();
        v0 = 0;
        w = 8'h81;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t5_new_aout", {31'd0, a0}, {31'd0, w[7-i]});
            chk("t5_new_fd", {31'd0, fd0}, (i == 7) ? 32'd1 : 32'd0);
            tick();
        end
        #1;
        chk("t5_new_fs", {16'd0, fs0}, 32'd1);

        // 3: LSB-first build, word 01
        d1 = 8'h01; v1 = 1;
        tick();
        v1 = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t3_aout", {31'd0, a1}, (i == 0) ? 32'd1 : 32'd0);
            chk("t3_bv", {31'd0, bv1}, 32'd1);
            chk("t3_fd", {31'd0, fd1}, (i == 7) ? 32'd1 : 32'd0);
            tick();
        end
        #1;
        chk("t3_fs", {16'd0, fs1}, 32'd1);
        chk("t3_idle_bv", {31'd0, bv1}, 32'd0);

        // 6: 2-bit counter, five back-to-back words wrap 1,2,3,0,1
        d2 = 8'hC3; v2 = 1;
        tick();
        w = 8'hC3;
        for (int j = 0; j < 40; j++) begin
            if (j == 32) v2 = 0;
            #1;
            chk("t6_fs", {30'd0, fs2}, 32'((j / 8) % 4));
            chk("t6_aout", {31'd0, a2}, {31'd0, w[7-(j%8)]});
            chk("t6_bv", {31'd0, bv2}, 32'd1);
            tick();
        end
        #1;
        chk("t6_fs_end", {30'd0, fs2}, 32'd1);
        chk("t6_idle_bv", {31'd0, bv2}, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
